// File: rtl/cordic_angle_sequencer.sv
// Control stage for the 6-bit CORDIC core. It folds full-circle angles into +/-90 deg, runs the core
// through reset/run/done, and returns quadrant-corrected cos/sin. Optional macro: CORDIC_SEQ_TIMEOUT_EN.
module cordic_angle_sequencer #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_angle,
    output logic       core_reset,
    output logic [5:0] core_z0,
    input  logic       core_done,
    input  logic [5:0] core_x,
    input  logic [5:0] core_y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_cos,
    output logic [5:0] out_sin,
    output logic       busy,
    output logic       err
);

    localparam int unsigned CNT_MAX = (RESET_CYCLES > TIMEOUT) ? RESET_CYCLES : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             neg;

    logic signed [8:0] ext_angle;
    logic signed [8:0] wrap_angle;
    logic signed [8:0] fold_angle;
    logic              fold_neg;
    logic [5:0]        cos_fix;

    // Wrap to [-62,61], then mirror the outer quadrants into the core's +/-31 range.
    always_comb begin
        ext_angle  = $signed({req_angle[7], req_angle});
        wrap_angle = ext_angle;
        if (ext_angle >= 9'sd62) begin
            wrap_angle = ext_angle - 9'sd124;
        end else if (ext_angle < -9'sd62) begin
            wrap_angle = ext_angle + 9'sd124;
        end
        fold_angle = wrap_angle;
        fold_neg   = 1'b0;
        if (wrap_angle > 9'sd31) begin
            fold_angle = 9'sd62 - wrap_angle;
            fold_neg   = 1'b1;
        end else if (wrap_angle < -9'sd31) begin
            fold_angle = -9'sd62 - wrap_angle;
            fold_neg   = 1'b1;
        end
    end

    // Mirrored angles need cos negated; -32 has no positive twin and saturates to +31.
    always_comb begin
        cos_fix = core_x;
        if (neg) begin
            cos_fix = (core_x == 6'h20) ? 6'h1f : 6'(-core_x);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            neg        <= 1'b0;
            req_ready  <= 1'b1;
            core_reset <= 1'b1;
            core_z0    <= '0;
            out_valid  <= 1'b0;
            out_cos    <= '0;
            out_sin    <= '0;
            busy       <= 1'b0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
            err        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        core_z0   <= fold_angle[5:0];
                        neg       <= fold_neg;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                        cnt        <= '0;
                        core_reset <= 1'b0;
                        state      <= S_RUN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (core_done) begin
                        out_cos <= cos_fix;
                        out_sin <= core_y;
                        state   <= S_CAPTURE;
                    end
`ifdef CORDIC_SEQ_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        err        <= 1'b1;
                        out_cos    <= '0;
                        out_sin    <= '0;
                        out_valid  <= 1'b1;
                        core_reset <= 1'b1;
                        state      <= S_OUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                S_CAPTURE: begin
                    core_reset <= 1'b1;
                    out_valid  <= 1'b1;
                    state      <= S_OUT;
                end
                S_OUT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef CORDIC_SEQ_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule
